// File: rtl/seq_shift_add_mult.sv
// Sequential radix-2 shift-add multiplier, one multiplier bit per clock.
// Handles unsigned or two's-complement operands, selected per operation.
module seq_shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [PW-1:0]     product_q, product_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              signed_q, signed_d;
    logic [PW-1:0]     addend;
    logic              last_step;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        product_d = product_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        signed_d  = signed_q;
        addend    = mplier_q[0] ? mcand_q : '0;
        last_step = (cnt_q == CW'(1));

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d  = signed_mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    signed_d = signed_mode;
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                // The multiplier MSB carries negative weight in two's complement.
                if (signed_q && last_step) begin
                    acc_d = acc_q - addend;
                end else begin
                    acc_d = acc_q + addend;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (last_step) begin
                    product_d = acc_d;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            product_q <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            signed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            product_q <= product_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            signed_q  <= signed_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: doc/seq_shift_add_mult.md
SEQ_SHIFT_ADD_MULT -- requirements
Module: seq_shift_add_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand width in bits; legal values are 2 to 16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin one multiplication.
REQ-005 SHALL have port signed_mode, input, 1: 1 = two's-complement operands, 0 = unsigned.
REQ-006 SHALL have port a, input, WIDTH, the multiplicand.
REQ-007 SHALL have port b, input, WIDTH, the multiplier.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse when the result becomes valid.
REQ-010 SHALL have port product, output, 2*WIDTH, the last completed result.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-012 In IDLE or DONE, start=1 at a rising edge SHALL capture a, b and signed_mode into internal registers, clear the accumulator, load the bit counter with WIDTH, and enter RUN.
REQ-013 Operand inputs and signed_mode SHALL be ignored outside the capture edge; changing them during RUN SHALL NOT affect the result.
REQ-014 Each RUN edge SHALL process exactly one multiplier bit, LSB first, as a radix-2 shift-add step, and SHALL decrement the counter.
REQ-015 In signed mode, the multiplicand SHALL be sign-extended to 2*WIDTH bits, and the step for the multiplier MSB SHALL subtract rather than add, so the result is the exact two's-complement product.
REQ-016 In unsigned mode, all steps SHALL add and the result SHALL be the exact unsigned product.
REQ-017 All accumulator arithmetic SHALL be performed modulo 2^(2*WIDTH); no overflow flag is produced, because the full product always fits.
REQ-018 The WIDTH-th RUN edge SHALL load product from the accumulator and enter DONE.
REQ-019 Latency: if capture occurs at edge E, done SHALL be high during the cycle after edge E+WIDTH, and SHALL be low otherwise.
REQ-020 busy SHALL be high exactly while the state is RUN.
REQ-021 From DONE without start, the next edge SHALL return to IDLE.
REQ-022 From DONE with start, the next edge SHALL capture new operands, allowing back-to-back operation with no idle cycle.
REQ-023 start while in RUN SHALL be ignored; the current operation continues unaffected.
REQ-024 product SHALL hold its value from the DONE load until the next DONE load; it SHALL NOT change during RUN.
REQ-025 A zero multiplicand or a zero multiplier SHALL still take the full WIDTH cycles and yield 0.

Reset
REQ-026 When rst_n=0, the block SHALL immediately (asynchronously) enter IDLE, with busy=0, done=0, product=0, and the counter and accumulator cleared.
REQ-027 Reset asserted during RUN SHALL abort the operation, discard the partial result, and leave product at 0.
REQ-028 After rst_n deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-029 The bench SHALL cover: WIDTH=4, unsigned, a=15, b=15, start at edge 0 -> busy high over edges 1-4, done pulse after edge 4, product=0xE1.
REQ-030 The bench SHALL cover: WIDTH=4, signed, a=-8 (0x8), b=-8 -> product=0x40; and a=-8, b=7 -> product=0xC8.
REQ-031 The bench SHALL cover: WIDTH=4, start pulsed again mid-RUN with different operands -> ignored; original product is delivered at the original latency.
REQ-032 The bench SHALL cover: rst_n pulsed low at edge 2 of RUN -> busy=0, done never pulses, product=0; then a new 3*5 request -> product=0x0F.
REQ-033 The bench SHALL cover: start held high through DONE -> second operation 6*7 captured with no gap; product=0x2A, and each done pulse lasts one cycle.
REQ-034 The bench SHALL cover: WIDTH=8, unsigned 255*255 -> product=0xFE01 after 8 RUN cycles; and signed -128*-128 -> product=0x4000.
